// File: rtl/mem_programmer_pkg.sv
// Shared encodings for the front-panel memory programmer: CPU mode codes
// driven by the CPU control block and the programmer FSM state codes.
package mem_programmer_pkg;

    typedef enum logic [1:0] {
        CPU_IDLE  = 2'b00,
        CPU_RUN   = 2'b01,
        CPU_LOAD  = 2'b10,
        CPU_CHECK = 2'b11
    } cpu_state_e;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WR_STROBE  = 3'd1,
        ST_RD_STROBE  = 3'd2,
        ST_RD_CAPTURE = 3'd3,
        ST_ADVANCE    = 3'd4
    } prog_state_e;

    // The panel owns the memory bus in both LOAD and CHECK, which share the top code bit.
    function automatic logic is_panel_mode(input cpu_state_e mode);
        return mode[1];
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Debouncer for a raw panel key. The debounced level follows the raw key only
// after DEBOUNCE_CYCLES consecutive samples that disagree with it; rise is a
// one-cycle pulse on each accepted 0->1 transition.
module key_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd8
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic level,
    output logic rise
);

    logic [15:0] stable_cnt;

    // Count consecutive mismatching samples; any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_cnt <= '0;
            level      <= 1'b0;
            rise       <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (key_in == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == DEBOUNCE_CYCLES - 16'd1) begin
                stable_cnt <= '0;
                level      <= key_in;
                rise       <= key_in;
            end else begin
                stable_cnt <= stable_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/mem_programmer.sv
// Front-panel memory initiator. While the CPU is in LOAD or CHECK, each
// debounced A1 press writes the switches to the current address (LOAD) or
// reads it into check_out (CHECK), then advances the address with wrap.
import mem_programmer_pkg::*;

module mem_programmer #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd8,
    parameter logic [7:0]  STROBE_CYCLES   = 8'd4,
    parameter logic [16:0] ADDR_LIMIT      = 17'd256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        A1,
    input  logic [1:0]  cpustate,
    input  logic [7:0]  D,
    input  logic [7:0]  rd_data,
    output logic [15:0] addr,
    output logic [7:0]  wr_data,
    output logic        read,
    output logic        write,
    output logic [7:0]  check_out,
    output logic        busy,
    output logic        active
);

    cpu_state_e  mode;
    cpu_state_e  prev_mode;
    prog_state_e state;
    logic [7:0]  strobe_cnt;
    logic        key_level;
    logic        key_rise;
    logic        step;
    logic        addr_at_limit;

    assign mode          = cpu_state_e'(cpustate);
    assign step          = key_rise & key_level;
    assign busy          = (state != ST_IDLE);
    assign addr_at_limit = ({1'b0, addr} == ADDR_LIMIT - 17'd1);

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_a1 (
        .clk    (clk),
        .rst    (rst),
        .key_in (A1),
        .level  (key_level),
        .rise   (key_rise)
    );

    // Access sequencer: strobes, capture and address advance; a mode change aborts everything.
    // NOTE: all state and outputs here are flops, so every assignment is non-blocking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            prev_mode  <= CPU_IDLE;
            strobe_cnt <= '0;
            addr       <= '0;
            wr_data    <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
            check_out  <= '0;
            active     <= 1'b0;
        end else begin
            prev_mode <= mode;
            active    <= is_panel_mode(mode);
            if (mode != prev_mode) begin
                state      <= ST_IDLE;
                strobe_cnt <= '0;
                addr       <= '0;
                read       <= 1'b0;
                write      <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        strobe_cnt <= '0;
                        if (step && mode == CPU_LOAD) begin
                            wr_data <= D;
                            write   <= 1'b1;
                            state   <= ST_WR_STROBE;
                        end else if (step && mode == CPU_CHECK) begin
                            read  <= 1'b1;
                            state <= ST_RD_STROBE;
                        end
                    end
                    ST_WR_STROBE: begin
                        if (strobe_cnt == STROBE_CYCLES - 8'd1) begin
                            write <= 1'b0;
                            state <= ST_ADVANCE;
                        end else begin
                            strobe_cnt <= strobe_cnt + 8'd1;
                        end
                    end
                    ST_RD_STROBE: begin
                        if (strobe_cnt == STROBE_CYCLES - 8'd1) begin
                            state <= ST_RD_CAPTURE;
                        end else begin
                            strobe_cnt <= strobe_cnt + 8'd1;
                        end
                    end
                    ST_RD_CAPTURE: begin
                        check_out <= rd_data;
                        read      <= 1'b0;
                        state     <= ST_ADVANCE;
                    end
                    ST_ADVANCE: begin
                        addr  <= addr_at_limit ? 16'd0 : addr + 16'd1;
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_programmer.sv
// Scoreboard bench for mem_programmer: stimulus pushes expected memory
// accesses, a negedge monitor pops and compares each strobe the DUT issues.
module tb_mem_programmer;

    localparam int STROBE = 3;

    typedef struct {
        bit          is_read;
        logic [15:0] addr;
        logic [7:0]  data;
        int          len;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        A1;
    logic [1:0]  cpustate;
    logic [7:0]  D;
    logic [7:0]  rd_data;
    logic [15:0] addr;
    logic [7:0]  wr_data;
    logic        read;
    logic        write;
    logic [7:0]  check_out;
    logic        busy;
    logic        active;

    logic [7:0]  mem [0:255];
    exp_t        sb[$];
    exp_t        cur_w;
    exp_t        cur_r;
    int          wlen;
    int          rlen;
    logic        write_q;
    logic        read_q;
    int          n_checks = 0;
    int          n_errors = 0;

    mem_programmer #(
        .DEBOUNCE_CYCLES(16'd4),
        .STROBE_CYCLES  (8'd3),
        .ADDR_LIMIT     (17'd256)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .A1        (A1),
        .cpustate  (cpustate),
        .D         (D),
        .rd_data   (rd_data),
        .addr      (addr),
        .wr_data   (wr_data),
        .read      (read),
        .write     (write),
        .check_out (check_out),
        .busy      (busy),
        .active    (active)
    );

    always #5 clk = ~clk;

    // Memory model: registered write, combinational read.
    assign rd_data = mem[addr[7:0]];
    always @(posedge clk) begin
        if (write) mem[addr[7:0]] <= wr_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected entry per strobe, checks address/data stability and length.
    always @(negedge clk) begin
        if (rst) begin
            write_q = 1'b0;
            read_q  = 1'b0;
        end else begin
            if (read || write) check("rd_wr_exclusive", {31'd0, read & write}, 32'd0);
            if (write && !write_q) begin
                check("sb_has_write", {31'd0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    cur_w = sb.pop_front();
                    check("sb_kind_write", {31'd0, cur_w.is_read}, 32'd0);
                end
                wlen = 0;
            end
            if (write) begin
                wlen++;
                check("wr_addr", {16'd0, addr}, {16'd0, cur_w.addr});
                check("wr_data", {24'd0, wr_data}, {24'd0, cur_w.data});
            end
            if (!write && write_q && cur_w.len != 0) check("wr_len", wlen, cur_w.len);
            if (read && !read_q) begin
                check("sb_has_read", {31'd0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    cur_r = sb.pop_front();
                    check("sb_kind_read", {31'd0, cur_r.is_read}, 32'd1);
                end
                rlen = 0;
            end
            if (read) begin
                rlen++;
                check("rd_addr", {16'd0, addr}, {16'd0, cur_r.addr});
            end
            if (!read && read_q) begin
                check("rd_len", rlen, cur_r.len);
                check("check_out", {24'd0, check_out}, {24'd0, cur_r.data});
            end
            write_q = write;
            read_q  = read;
        end
    end

    task automatic push_wr(input logic [15:0] a, input logic [7:0] d, input int len);
        exp_t e;
        e.is_read = 1'b0; e.addr = a; e.data = d; e.len = len;
        sb.push_back(e);
    endtask

    task automatic push_rd(input logic [15:0] a, input logic [7:0] d);
        exp_t e;
        e.is_read = 1'b1; e.addr = a; e.data = d; e.len = STROBE + 1;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            if (!busy) done = 1'b1;
            else @(negedge clk);
        end
        check("idle_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic press();
        A1 = 1'b1;
        repeat (8) @(negedge clk);
        A1 = 1'b0;
        repeat (8) @(negedge clk);
        wait_idle();
    endtask

    task automatic enter_mode(input logic [1:0] m);
        cpustate = 2'b00;
        repeat (2) @(negedge clk);
        cpustate = m;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        bit seen;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst = 1'b1; A1 = 1'b1; cpustate = 2'b00; D = 8'h00;

        // 1: reset with key held; all outputs zero, no step afterwards
        repeat (2) @(negedge clk);
        check("rst_addr",      {16'd0, addr}, 32'd0);
        check("rst_wr_data",   {24'd0, wr_data}, 32'd0);
        check("rst_read",      {31'd0, read}, 32'd0);
        check("rst_write",     {31'd0, write}, 32'd0);
        check("rst_check_out", {24'd0, check_out}, 32'd0);
        check("rst_busy",      {31'd0, busy}, 32'd0);
        check("rst_active",    {31'd0, active}, 32'd0);
        A1 = 1'b0; rst = 1'b0;
        repeat (10) @(negedge clk);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        // 2: LOAD, single clean press of A5
        enter_mode(2'b10);
        check("load_active", {31'd0, active}, 32'd1);
        check("load_addr0",  {16'd0, addr}, 32'd0);
        D = 8'hA5;
        push_wr(16'd0, 8'hA5, STROBE);
        press();
        check("addr_after_a5", {16'd0, addr}, 32'd1);

        // 3: bouncing key produces exactly one write
        D = 8'h3C;
        push_wr(16'd1, 8'h3C, STROBE);
        A1 = 1'b1; @(negedge clk);
        A1 = 1'b0; @(negedge clk);
        A1 = 1'b1; @(negedge clk);
        A1 = 1'b0; @(negedge clk);
        press();
        check("addr_after_bounce", {16'd0, addr}, 32'd2);

        // 4: LOAD 11,22,33 then CHECK reads them back
        enter_mode(2'b10);
        D = 8'h11; push_wr(16'd0, 8'h11, STROBE); press();
        D = 8'h22; push_wr(16'd1, 8'h22, STROBE); press();
        D = 8'h33; push_wr(16'd2, 8'h33, STROBE); press();
        enter_mode(2'b11);
        check("check_active", {31'd0, active}, 32'd1);
        push_rd(16'd0, 8'h11); press();
        push_rd(16'd1, 8'h22); press();
        push_rd(16'd2, 8'h33); press();
        check("addr_after_check", {16'd0, addr}, 32'd3);

        // 5: address wrap at the last word
        enter_mode(2'b10);
        for (int i = 0; i < 255; i++) begin
            D = 8'(i);
            push_wr(16'(i), 8'(i), STROBE);
            press();
        end
        check("addr_preload_255", {16'd0, addr}, 32'h00FF);
        D = 8'h5A;
        push_wr(16'h00FF, 8'h5A, STROBE);
        press();
        check("addr_wrap_0", {16'd0, addr}, 32'd0);

        // 6: abort mid-write by switching to RUN; later press discarded
        D = 8'h77;
        push_wr(16'd0, 8'h77, 0);
        A1 = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (write) seen = 1'b1;
        end
        check("abort_write_seen", {31'd0, seen}, 32'd1);
        cpustate = 2'b01;
        @(negedge clk);
        check("abort_write_low",  {31'd0, write}, 32'd0);
        check("abort_active_low", {31'd0, active}, 32'd0);
        check("abort_busy_low",   {31'd0, busy}, 32'd0);
        check("abort_addr_0",     {16'd0, addr}, 32'd0);
        A1 = 1'b0;
        repeat (8) @(negedge clk);
        D = 8'hEE;
        press();
        check("run_press_addr", {16'd0, addr}, 32'd0);
        check("run_press_busy", {31'd0, busy}, 32'd0);
        check("check_out_kept", {24'd0, check_out}, 32'h33);

        repeat (4) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
